// File: rtl/matmul_4x4_seq_ctrl.sv
// rtl/matmul_4x4_seq_ctrl.sv - fetch/compute/write sequencer for the 4x4 int8 systolic matmul.
// Optional COMPUTE watchdog enabled by defining MATMUL_CTRL_TIMEOUT_EN.
module matmul_4x4_seq_ctrl #(
  parameter int ADDR_WIDTH     = 7,
  parameter int MAT_SIZE       = 4,
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_mat_mul_i,
  input  logic [ADDR_WIDTH-1:0] a_loc_i,
  input  logic [ADDR_WIDTH-1:0] b_loc_i,
  input  logic [ADDR_WIDTH-1:0] c_loc_i,
  output logic                  a_en_o,
  output logic [ADDR_WIDTH-1:0] a_addr_o,
  output logic                  b_en_o,
  output logic [ADDR_WIDTH-1:0] b_addr_o,
  output logic                  array_start_o,
  input  logic                  array_done_i,
  output logic                  c_we_o,
  output logic [ADDR_WIDTH-1:0] c_addr_o,
  output logic [1:0]            c_row_sel_o,
  output logic                  busy_o,
  output logic                  done_mat_mul_o,
  output logic                  error_o
);

  localparam int KW = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [ADDR_WIDTH-1:0] a_base_q, a_base_d;
  logic [ADDR_WIDTH-1:0] b_base_q, b_base_d;
  logic [ADDR_WIDTH-1:0] c_base_q, c_base_d;
  logic [RD_LATENCY-1:0] launch_q, launch_d;
  logic                  launched_q, launched_d;
  logic                  error_q, error_d;
  logic                  last_k;
  logic                  wd_expire;

  assign last_k        = (k_q == KW'(MAT_SIZE - 1));
  // array_start trails the first fetch cycle by the BRAM read latency
  assign array_start_o = launch_q[RD_LATENCY-1];
  assign error_o       = error_q;

`ifdef MATMUL_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;

  assign wd_expire = (wd_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = '0;
    if (state_q == S_COMPUTE) wd_d = wd_q + TW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    a_base_d       = a_base_q;
    b_base_d       = b_base_q;
    c_base_d       = c_base_q;
    error_d        = error_q;
    launched_d     = launched_q | array_start_o;
    a_en_o         = 1'b0;
    b_en_o         = 1'b0;
    a_addr_o       = '0;
    b_addr_o       = '0;
    c_we_o         = 1'b0;
    c_addr_o       = '0;
    c_row_sel_o    = 2'd0;
    busy_o         = 1'b0;
    done_mat_mul_o = 1'b0;

    launch_d[0] = (state_q == S_FETCH) && (k_q == '0);
    for (int i = 1; i < RD_LATENCY; i++) launch_d[i] = launch_q[i-1];

    case (state_q)
      S_IDLE: begin
        if (start_mat_mul_i) begin
          a_base_d   = a_loc_i;
          b_base_d   = b_loc_i;
          c_base_d   = c_loc_i;
          k_d        = '0;
          error_d    = 1'b0;
          launched_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        busy_o   = 1'b1;
        a_en_o   = 1'b1;
        b_en_o   = 1'b1;
        a_addr_o = a_base_q + ADDR_WIDTH'(k_q);
        b_addr_o = b_base_q + ADDR_WIDTH'(k_q);
        k_d      = k_q + KW'(1);
        if (last_k) begin
          k_d     = '0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        busy_o = 1'b1;
        // a done seen before the array was actually launched cannot belong to this job
        if (array_done_i && launched_q) begin
          k_d     = '0;
          state_d = S_WRITE;
        end else if (wd_expire) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        busy_o      = 1'b1;
        c_we_o      = 1'b1;
        c_addr_o    = c_base_q + ADDR_WIDTH'(k_q);
        c_row_sel_o = 2'(k_q);
        k_d         = k_q + KW'(1);
        if (last_k) begin
          k_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_mat_mul_o = 1'b1;
        if (!start_mat_mul_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      launch_q   <= '0;
      launched_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      c_base_q   <= c_base_d;
      launch_q   <= launch_d;
      launched_q <= launched_d;
      error_q    <= error_d;
    end
  end

endmodule
